// File: rtl/div_pkg.sv
// div_pkg: shared types and sizing for the sequential divider.
package div_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITER = 32;
    localparam int CNT_W = $clog2(DIV_ITER);
    typedef enum logic [1:0] {IDLE, DBZ, ON, DONE} div_state_e;
    function automatic logic [DIV_WIDTH-1:0] magnitude(input logic [DIV_WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring radix-2 step (trial subtract, next remainder, quotient bit).
module div_step
    import div_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] rem_i,
    input  logic                 msb_i,
    input  logic [DIV_WIDTH-1:0] dvs_i,
    output logic [DIV_WIDTH-1:0] rem_o,
    output logic                 q_o
);
    logic [DIV_WIDTH:0] shifted;
    assign shifted = {rem_i, msb_i};
    assign q_o = shifted >= {1'b0, dvs_i};
    // A successful subtract always leaves less than the divisor, so 32 bits suffice.
    assign rem_o = q_o ? shifted[DIV_WIDTH-1:0] - dvs_i : shifted[DIV_WIDTH-1:0];
endmodule

// File: rtl/seq_div.sv
// seq_div: 32-bit signed/unsigned sequential divider, one quotient bit per cycle.
module seq_div
    import div_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   annul_i,
    input  logic                   start_i,
    input  logic                   signed_div_i,
    input  logic [DIV_WIDTH-1:0]   opdata1_i,
    input  logic [DIV_WIDTH-1:0]   opdata2_i,
    output logic                   ready_o,
    output logic [2*DIV_WIDTH-1:0] result_o
);
    div_state_e             state_q, state_d;
    logic [DIV_WIDTH-1:0]   dvs_q, rem_q, quot_q, step_rem, quo_fin;
    logic [CNT_W-1:0]       cnt_q;
    logic                   neg_quo_q, neg_rem_q, step_q, abort, accept, last;
    logic                   ready_q, ready_d;
    logic [2*DIV_WIDTH-1:0] result_q, result_d, fixed;

    assign abort   = flush | annul_i;
    assign accept  = (state_q == IDLE) && start_i && !abort;
    assign last    = cnt_q == CNT_W'(DIV_ITER - 1);
    assign quo_fin = {quot_q[DIV_WIDTH-2:0], step_q};
    assign fixed   = {magnitude(step_rem, neg_rem_q), magnitude(quo_fin, neg_quo_q)};
    assign ready_o  = ready_q;
    assign result_o = result_q;

    div_step u_step (
        .rem_i (rem_q),
        .msb_i (quot_q[DIV_WIDTH-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? (opdata2_i == '0 ? DBZ : ON) : IDLE;
            DBZ:     state_d = abort ? IDLE : DONE;
            ON:      state_d = abort ? IDLE : (last ? DONE : ON);
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_d  = state_d == DONE;
        result_d = (state_q == DBZ && state_d == DONE) ? '0 :
                   (state_q == ON && state_d == DONE)  ? fixed : result_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q  <= 1'b0;
            result_q <= '0;
        end else begin
            ready_q  <= ready_d;
            result_q <= result_d;
        end
    end

    // Operands are reduced to magnitudes on entry; signs are reapplied on the final step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvs_q     <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (accept) begin
            dvs_q     <= magnitude(opdata2_i, signed_div_i & opdata2_i[DIV_WIDTH-1]);
            quot_q    <= magnitude(opdata1_i, signed_div_i & opdata1_i[DIV_WIDTH-1]);
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= signed_div_i & (opdata1_i[DIV_WIDTH-1] ^ opdata2_i[DIV_WIDTH-1]);
            neg_rem_q <= signed_div_i & opdata1_i[DIV_WIDTH-1];
        end else if (state_q == ON) begin
            rem_q  <= step_rem;
            quot_q <= quo_fin;
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: table, random and hand-written sequence checks for seq_div.
module tb_seq_div;
    logic        clk = 1'b0, rst = 1'b0, flush = 1'b0, annul_i = 1'b0, start_i = 1'b0, signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0, opdata2_i = '0;
    logic        ready_o;
    logic [63:0] result_o;
    int          n_vec = 0, n_err = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [63:0] res;
        int          lat;
    } vec_t;
    vec_t tbl[9];

    seq_div dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .annul_i      (annul_i),
        .start_i      (start_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .ready_o      (ready_o),
        .result_o     (result_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Truncating division in 64-bit arithmetic, so the most negative quotient cannot overflow.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa, sb;
        logic [31:0] q, r;
        if (b == 0) return 64'h0;
        sa = sgn ? longint'($signed(a)) : longint'({32'h0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'h0, b});
        q = 32'(sa / sb);
        r = 32'(sa % sb);
        return {r, q};
    endfunction

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           output logic [63:0] res, output int lat);
        @(negedge clk);
        start_i = 1'b1; opdata1_i = a; opdata2_i = b; signed_div_i = sgn;
        @(negedge clk);
        start_i = 1'b0; opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = 1'($urandom);
        lat = 0;
        res = 'x;
        for (int c = 1; c <= 60; c++) begin
            if (ready_o) begin
                lat = c;
                res = result_o;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic expect_quiet(input string name, input int n);
        int seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        check(name, 64'(seen), 64'h0);
    endtask

    task automatic apply(input string name, input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [63:0] exp_res, input int exp_lat);
        logic [63:0] res;
        int lat;
        run_div(a, b, sgn, res, lat);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " result"}, res, exp_res);
        @(negedge clk);
        check({name, " one-pulse"}, 64'(ready_o), 64'h0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        s;
        logic [63:0] res, held;
        int          lat;
        tbl[0] = '{32'd100,       32'd7,         1'b0, 64'h00000002_0000000E, 33};
        tbl[1] = '{32'hFFFFFFF9,  32'd2,         1'b1, 64'hFFFFFFFF_FFFFFFFD, 33};
        tbl[2] = '{32'd7,         32'hFFFFFFFE,  1'b1, 64'h00000001_FFFFFFFD, 33};
        tbl[3] = '{32'h12345678,  32'd0,         1'b0, 64'h0,                 2};
        tbl[4] = '{32'h12345678,  32'd0,         1'b1, 64'h0,                 2};
        tbl[5] = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 64'h00000000_80000000, 33};
        tbl[6] = '{32'h80000000,  32'hFFFFFFFF,  1'b0, 64'h80000000_00000000, 33};
        tbl[7] = '{32'hFFFFFFFF,  32'd1,         1'b0, 64'h00000000_FFFFFFFF, 33};
        tbl[8] = '{32'd5,         32'd10,        1'b1, 64'h00000005_00000000, 33};

        repeat (3) @(negedge clk);
        check("reset ready", 64'(ready_o), 64'h0);
        check("reset result", result_o, 64'h0);
        rst = 1'b1;
        expect_quiet("idle no start", 5);

        for (int i = 0; i < 9; i++) apply($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].sgn, tbl[i].res, tbl[i].lat);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
            s = 1'($urandom);
            apply($sformatf("rnd%0d", i), a, b, s, model(a, b, s), b == 0 ? 2 : 33);
        end

        // Flush at cycle 10 aborts silently and leaves the prior result in place.
        held = result_o;
        @(negedge clk);
        start_i = 1'b1; opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        expect_quiet("flush no ready", 40);
        check("flush result held", result_o, held);
        repeat (3) @(negedge clk);
        apply("after flush", 32'd1000, 32'd3, 1'b0, 64'h00000001_0000014D, 33);

        // Annul while waiting out a zero divisor.
        @(negedge clk);
        start_i = 1'b1; opdata1_i = 32'h12345678; opdata2_i = 32'd0;
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        expect_quiet("annul dbz", 10);
        check("annul dbz result held", result_o, 64'h00000001_0000014D);

        // Flush in DONE: the pulse is already out, the divider simply returns to IDLE.
        run_div(32'd77, 32'd5, 1'b0, res, lat);
        check("done flush latency", 64'(lat), 64'd33);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("done flush ready", 64'(ready_o), 64'h0);
        check("done flush result", result_o, 64'h00000002_0000000F);

        // Start concurrent with flush is ignored.
        @(negedge clk);
        start_i = 1'b1; flush = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd2;
        @(negedge clk);
        start_i = 1'b0; flush = 1'b0;
        expect_quiet("start with flush", 40);

        // Asynchronous reset mid-division clears outputs at once and nothing resumes.
        @(negedge clk);
        start_i = 1'b1; opdata1_i = 32'd50000; opdata2_i = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        repeat (19) @(negedge clk);
        check("pre-reset result", result_o, 64'h00000002_0000000F);
        #1 rst = 1'b0;
        #1;
        check("async reset ready", 64'(ready_o), 64'h0);
        check("async reset result", result_o, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        expect_quiet("after reset quiet", 40);
        check("after reset result", result_o, 64'h0);

        apply("post reset", 32'd50000, 32'd7, 1'b0, model(32'd50000, 32'd7, 1'b0), 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately.
REQ-003 flush  input  1  pipeline flush; aborts any in-flight division.
REQ-004 annul_i  input  1  initiator cancel; same effect as flush.
REQ-005 start_i  input  1  level request from initiator; sampled only in IDLE.
REQ-006 signed_div_i  input  1  1 = signed (two's complement), 0 = unsigned; sampled with start_i.
REQ-007 opdata1_i  input  32  dividend; sampled with start_i.
REQ-008 opdata2_i  input  32  divisor; sampled with start_i.
REQ-009 ready_o  output  1  registered; high for exactly one cycle when result_o is valid.
REQ-010 result_o  output  64  registered; {remainder[63:32], quotient[31:0]} (hi/lo order).

Function
REQ-011 FSM states: IDLE, DBZ, ON, DONE; held in one state register.
REQ-012 IDLE: start_i=1 and no flush/annul -> latch operands and sign mode; divisor==0 -> DBZ, else -> ON with iteration counter=0.
REQ-013 IDLE: start_i=0 -> remain IDLE; ready_o=0.
REQ-014 Signed mode: operands converted to 32-bit magnitudes at latch time; original dividend and divisor sign bits retained.
REQ-015 ON: one restoring radix-2 step per cycle (33-bit trial subtract of divisor magnitude from partial remainder, quotient bit shifted in); 32 steps, counter 0..31.
REQ-016 ON after step 31 -> DONE; result_o loaded in the same edge.
REQ-017 Signed fix-up: quotient negated when dividend and divisor signs differ; remainder negated when dividend negative; all arithmetic mod 2^32.
REQ-018 0x80000000 / 0xFFFFFFFF signed: quotient 0x80000000, remainder 0x00000000; no exception, no extra cycle.
REQ-019 DBZ: -> DONE next cycle with result_o = 64'h0.
REQ-020 DONE: ready_o=1 for this cycle only; -> IDLE next cycle unconditionally; start_i ignored in DONE.
REQ-021 Latency: start_i sampled at cycle 0 -> ready_o at cycle 33 (nonzero divisor) or cycle 2 (zero divisor).
REQ-022 Operand inputs changing after cycle 0 shall not affect the result.
REQ-023 flush or annul_i high in DBZ or ON -> IDLE next edge; ready_o stays 0; result_o keeps its prior value.
REQ-024 flush or annul_i in DONE -> IDLE next edge; the ready_o pulse already issued is not retracted.
REQ-025 flush/annul_i concurrent with start_i in IDLE -> request ignored, remain IDLE.
REQ-026 result_o holds its last value outside DONE; it is valid only while ready_o=1.
REQ-027 start_i still high in the cycle after DONE is treated as a new request; the initiator de-asserts start_i on ready_o.

Reset
REQ-028 rst=0 -> state IDLE, ready_o=0, result_o=64'h0, counter=0, partial remainder/quotient/latched operands=0, regardless of state.
REQ-029 Reset release mid-operation shall not resume the aborted division; first activity after release requires a new start_i in IDLE.

Structure
REQ-030 Shared package div_pkg holds the state enum typedef, DIV_WIDTH=32, and DIV_ITER=32.
REQ-031 One combinational sub-module div_step (33-bit trial subtract, next remainder, quotient bit) is instantiated once in seq_div.
REQ-032 No multiplier or `/` / `%` operators in synthesizable RTL.

Verification
REQ-033 Unsigned 100/7 (signed_div_i=0) -> ready_o at cycle 33, result_o=64'h00000002_0000000E.
REQ-034 Signed -7/2 (0xFFFFFFF9, 0x00000002) -> result_o=64'hFFFFFFFF_FFFFFFFD; signed 7/-2 -> 64'h00000001_FFFFFFFD.
REQ-035 Divisor 0, dividend 0x12345678 -> ready_o at cycle 2, result_o=64'h0.
REQ-036 0x80000000/0xFFFFFFFF signed -> 64'h00000000_80000000; unsigned -> 64'h80000000_00000000.
REQ-037 flush pulse at cycle 10 of 1000/3 -> no ready_o; new start_i 5 cycles later with 1000/3 -> 64'h00000001_0000014D at 33 cycles after that start.
REQ-038 rst=0 at cycle 20 of an active division -> ready_o=0 and result_o=0 immediately; after release, with start_i=0 for 40 cycles -> ready_o stays 0.
